// File: rtl/gmii_pkt_gen_if.sv
// Control, status and GMII transmit bundle for gmii_pkt_gen.
// The master drives start/stop/frame count; the slave (the generator) drives GMII and status.
interface gmii_pkt_gen_if;
    logic        i_start;
    logic [15:0] iv_pkt_num;
    logic        i_stop;
    logic [7:0]  ov_gmii_txd;
    logic        o_gmii_tx_en;
    logic        o_gmii_tx_er;
    logic        o_busy;
    logic [31:0] ov_sent_cnt;

    modport master (
        output i_start, iv_pkt_num, i_stop,
        input  ov_gmii_txd, o_gmii_tx_en, o_gmii_tx_er, o_busy, ov_sent_cnt
    );

    modport slave (
        input  i_start, iv_pkt_num, i_stop,
        output ov_gmii_txd, o_gmii_tx_en, o_gmii_tx_er, o_busy, ov_sent_cnt
    );
endinterface

// File: rtl/gmii_pkt_gen.sv
// GMII test-frame generator: fixed-length sequence-numbered frames with an exact inter-frame gap.
// Define GMII_PKT_GEN_FCS_EN to send the Ethernet CRC-32 in the tail; otherwise the tail continues the payload pattern.
module gmii_pkt_gen #(
    parameter int unsigned FRAME_BYTES = 75,
    parameter int unsigned IFG         = 12,
    parameter logic [47:0] DMAC        = 48'h01_02_03_04_05_06,
    parameter logic [47:0] SMAC        = 48'h0A_0B_0C_0D_0E_0F,
    parameter logic [15:0] ETHTYPE     = 16'h1800
) (
    input  logic          i_clk,
    input  logic          i_rst,
    gmii_pkt_gen_if.slave bus
);
    localparam logic [111:0] HDR       = {DMAC, SMAC, ETHTYPE};
    localparam logic [11:0]  PAY_LAST  = 12'(FRAME_BYTES - 27);
    localparam logic [11:0]  TAIL_PAT0 = 12'(FRAME_BYTES - 30);
    localparam logic [11:0]  GAP_LAST  = 12'(IFG - 1);

    typedef enum logic [2:0] {IDLE, PRE, HDR_S, PAY, TAIL, GAP} state_t;

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [15:0] remain_q, remain_d;
    logic        cont_q, cont_d;
    logic        stop_q, stop_d;
    logic [31:0] seq_q, seq_d;
    logic [31:0] sent_q, sent_d;
    logic [7:0]  txd_q, txd_d;
    logic        txen_q, txen_d;
    logic        busy_q, busy_d;
    logic        stop_seen;
    logic [6:0]  hdr_bit;
    logic [4:0]  seq_bit;
`ifdef GMII_PKT_GEN_FCS_EN
    logic [31:0] crc_q, crc_d;
    logic [4:0]  tail_bit;
`endif

    // Outputs are registered from the current state, so the wire lags the FSM by one cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 12'd1;
        remain_d  = remain_q;
        cont_d    = cont_q;
        stop_d    = stop_q;
        seq_d     = seq_q;
        sent_d    = sent_q;
        txd_d     = '0;
        txen_d    = 1'b0;
        busy_d    = (state_q != IDLE);
        hdr_bit   = {4'd13 - cnt_q[3:0], 3'b000};
        seq_bit   = {~cnt_q[1:0], 3'b000};
        stop_seen = stop_q | bus.i_stop;
`ifdef GMII_PKT_GEN_FCS_EN
        tail_bit  = {cnt_q[1:0], 3'b000};
`endif
        if (state_q != IDLE) stop_d = stop_seen;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                stop_d = 1'b0;
                if (bus.i_start) begin
                    state_d  = PRE;
                    remain_d = bus.iv_pkt_num;
                    cont_d   = (bus.iv_pkt_num == 16'd0);
                    seq_d    = '0;
                end
            end
            PRE: begin
                txen_d = 1'b1;
                txd_d  = (cnt_q == 12'd7) ? 8'hD5 : 8'h55;
                if (cnt_q == 12'd7) begin
                    state_d = HDR_S;
                    cnt_d   = '0;
                end
            end
            HDR_S: begin
                txen_d = 1'b1;
                txd_d  = HDR[hdr_bit +: 8];
                if (cnt_q == 12'd13) begin
                    state_d = PAY;
                    cnt_d   = '0;
                end
            end
            PAY: begin
                txen_d = 1'b1;
                txd_d  = (cnt_q < 12'd4) ? seq_q[seq_bit +: 8] : 8'(cnt_q - 12'd4);
                if (cnt_q == PAY_LAST) begin
                    state_d = TAIL;
                    cnt_d   = '0;
                end
            end
            TAIL: begin
                txen_d = 1'b1;
`ifdef GMII_PKT_GEN_FCS_EN
                txd_d  = ~crc_q[tail_bit +: 8];
`else
                txd_d  = 8'(TAIL_PAT0 + cnt_q);
`endif
                if (cnt_q == 12'd3) begin
                    cnt_d  = '0;
                    sent_d = sent_q + 32'd1;
                    seq_d  = seq_q + 32'd1;
                    if (!cont_q) remain_d = remain_q - 16'd1;
                    if (stop_seen || (!cont_q && remain_q == 16'd1)) begin
                        state_d = IDLE;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (stop_seen) begin
                        state_d = IDLE;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = PRE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef GMII_PKT_GEN_FCS_EN
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int unsigned i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // CRC runs on the byte being launched, so it is final by the first tail byte.
    always_comb begin
        crc_d = crc_q;
        if (state_q == PRE) crc_d = '1;
        else if (state_q == HDR_S || state_q == PAY) crc_d = crc32_byte(crc_q, txd_d);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) crc_q <= '1;
        else       crc_q <= crc_d;
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            remain_q <= '0;
            cont_q   <= 1'b0;
            stop_q   <= 1'b0;
            seq_q    <= '0;
            sent_q   <= '0;
            txd_q    <= '0;
            txen_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            remain_q <= remain_d;
            cont_q   <= cont_d;
            stop_q   <= stop_d;
            seq_q    <= seq_d;
            sent_q   <= sent_d;
            txd_q    <= txd_d;
            txen_q   <= txen_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.ov_gmii_txd  = txd_q;
    assign bus.o_gmii_tx_en = txen_q;
    assign bus.o_gmii_tx_er = 1'b0;
    assign bus.o_busy       = busy_q;
    assign bus.ov_sent_cnt  = sent_q;
endmodule

// File: tb/tb_gmii_pkt_gen.sv
// Self-checking bench for gmii_pkt_gen: byte table for the first run plus directed multi-cycle sequences.
`timescale 1ns/1ps
module tb_gmii_pkt_gen;
    localparam int MAXF = 16;
    localparam int MAXB = 80;

    typedef struct {
        int         f;
        int         pos;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #4 clk = ~clk;

    gmii_pkt_gen_if bus();

    gmii_pkt_gen #(
        .FRAME_BYTES(75),
        .IFG(12),
        .DMAC(48'h01_02_03_04_05_06),
        .SMAC(48'h0A_0B_0C_0D_0E_0F),
        .ETHTYPE(16'h1800)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] fbuf [MAXF][MAXB];
    int flen [MAXF];
    int gaplen [MAXF];
    int nfr, first_en, first_busy, last_fall, busy_fall, n_busy_fall, dip_total, er_seen;
    bit done;
    vec_t tbl [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

`ifdef GMII_PKT_GEN_FCS_EN
    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'd0, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction
`endif

    // Drives one run and records every frame, gap and busy edge seen on the wire.
    // stop_pos >= 0: pulse i_stop after that many bytes of frame stop_frame;
    // stop_pos < 0: pulse i_stop after -stop_pos gap cycles following frame stop_frame-1.
    task automatic run(input logic [15:0] pn, input int start_hold, input int stop_frame,
                       input int stop_pos, input int max_cyc);
        int cur_len = 0;
        int low_run = 0;
        int done_c  = 0;
        int dip     = 0;
        bit prev_busy = 1'b0;
        bit dipping   = 1'b0;
        bit en, busy;
        nfr = 0; first_en = -1; first_busy = -1; last_fall = -1; busy_fall = -1;
        n_busy_fall = 0; dip_total = 0; er_seen = 0; done = 1'b0;
        for (int i = 0; i < MAXF; i++) begin
            flen[i] = 0;
            gaplen[i] = 0;
        end
        @(negedge clk);
        bus.iv_pkt_num = pn;
        bus.i_start    = (start_hold > 0);
        bus.i_stop     = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            en   = bus.o_gmii_tx_en;
            busy = bus.o_busy;
            if (bus.o_gmii_tx_er) er_seen++;
            if (en) begin
                if (first_en < 0) first_en = c;
                if (cur_len == 0 && nfr > 0 && nfr <= MAXF) gaplen[nfr-1] = low_run;
                if (nfr < MAXF && cur_len < MAXB) fbuf[nfr][cur_len] = bus.ov_gmii_txd;
                cur_len++;
                low_run = 0;
            end else begin
                if (cur_len > 0) begin
                    if (nfr < MAXF) flen[nfr] = cur_len;
                    nfr++;
                    cur_len = 0;
                    last_fall = c;
                end
                low_run++;
            end
            if (busy) begin
                if (first_busy < 0) first_busy = c;
                if (dipping) begin
                    dip_total += dip;
                    dipping = 1'b0;
                end
            end else if (prev_busy) begin
                busy_fall = c;
                n_busy_fall++;
                dipping = 1'b1;
                dip = 1;
            end else if (dipping) begin
                dip++;
            end
            prev_busy = busy;
            bus.i_start = (c < start_hold);
            bus.i_stop  = (stop_frame >= 0 && nfr == stop_frame &&
                           ((stop_pos >= 0 && en && cur_len == stop_pos) ||
                            (stop_pos < 0 && !en && cur_len == 0 && low_run == -stop_pos)));
            if (!done && c > start_hold && first_busy >= 0 && !busy && !en) begin
                done = 1'b1;
                done_c = c;
            end
            if (done && c >= done_c + 20) break;
        end
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        check("run_terminates", 32'(done), 32'd1);
    endtask

    initial begin
        logic [7:0] exp_b;
        int n_en;
        bit found;
`ifdef GMII_PKT_GEN_FCS_EN
        logic [31:0] crc, res, res_rev, tmp;
`endif
        bus.i_start = 1'b0;
        bus.i_stop = 1'b0;
        bus.iv_pkt_num = '0;

        tbl[0]  = '{0, 0,  8'h55};
        tbl[1]  = '{0, 6,  8'h55};
        tbl[2]  = '{0, 7,  8'hD5};
        tbl[3]  = '{0, 8,  8'h01};
        tbl[4]  = '{0, 13, 8'h06};
        tbl[5]  = '{0, 14, 8'h0A};
        tbl[6]  = '{0, 19, 8'h0F};
        tbl[7]  = '{0, 20, 8'h18};
        tbl[8]  = '{0, 21, 8'h00};
        tbl[9]  = '{0, 22, 8'h00};
        tbl[10] = '{0, 25, 8'h00};
        tbl[11] = '{0, 26, 8'h00};
        tbl[12] = '{0, 27, 8'h01};
        tbl[13] = '{0, 28, 8'h02};
        tbl[14] = '{0, 70, 8'h2C};
        tbl[15] = '{1, 24, 8'h00};
        tbl[16] = '{1, 25, 8'h01};
        tbl[17] = '{2, 25, 8'h02};

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_txd",   32'(bus.ov_gmii_txd), 32'h00);
        check("rst_tx_en", 32'(bus.o_gmii_tx_en), 32'd0);
        check("rst_tx_er", 32'(bus.o_gmii_tx_er), 32'd0);
        check("rst_busy",  32'(bus.o_busy), 32'd0);
        check("rst_sent",  bus.ov_sent_cnt, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Three-frame run
        run(16'd3, 1, -1, 0, 1000);
        check("latency_tx_en", 32'(first_en), 32'd2);
        check("latency_busy", 32'(first_busy), 32'd2);
        check("run1_frames", 32'(nfr), 32'd3);
        for (int i = 0; i < 3; i++) check($sformatf("run1_len%0d", i), 32'(flen[i]), 32'd75);
        for (int i = 0; i < 2; i++) check($sformatf("run1_gap%0d", i), 32'(gaplen[i]), 32'd12);
        check("run1_sent", bus.ov_sent_cnt, 32'd3);
        check("run1_busy_end", 32'(bus.o_busy), 32'd0);
        check("run1_busy_with_tx_en", 32'(busy_fall - last_fall), 32'd0);
        check("run1_tx_er", 32'(er_seen), 32'd0);
        for (int i = 0; i < 18; i++)
            check($sformatf("byte_f%0d_%0d", tbl[i].f, tbl[i].pos),
                  32'(fbuf[tbl[i].f][tbl[i].pos]), 32'(tbl[i].exp));
`ifdef GMII_PKT_GEN_FCS_EN
        crc = '1;
        for (int p = 8; p <= 70; p++) crc = crc_upd(crc, fbuf[0][p]);
        crc = ~crc;
        for (int j = 0; j < 4; j++) begin
            tmp = crc >> (8 * j);
            exp_b = tmp[7:0];
            check($sformatf("fcs_byte%0d", j), 32'(fbuf[0][71+j]), 32'(exp_b));
        end
        res = '1;
        for (int p = 8; p <= 74; p++) res = crc_upd(res, fbuf[0][p]);
        res_rev = {<<{res}};
        check("fcs_residue", res_rev, 32'hC704DD7B);
`else
        for (int j = 0; j < 4; j++) begin
            exp_b = 8'h2D + 8'(j);
            check($sformatf("tail_byte%0d", j), 32'(fbuf[0][71+j]), 32'(exp_b));
        end
        check("tail_f2_last", 32'(fbuf[2][74]), 32'h30);
`endif

        // Reset in the middle of the payload
        @(negedge clk);
        bus.iv_pkt_num = 16'd0;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        n_en = 0;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.o_gmii_tx_en) n_en++;
            if (n_en == 40) begin
                found = 1'b1;
                break;
            end
        end
        check("rst_reach_pay", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_tx_en", 32'(bus.o_gmii_tx_en), 32'd0);
        check("midrst_txd",   32'(bus.ov_gmii_txd), 32'h00);
        check("midrst_busy",  32'(bus.o_busy), 32'd0);
        check("midrst_sent",  bus.ov_sent_cnt, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Continuous run, stop during frame 5
        run(16'd0, 1, 5, 30, 2000);
        check("stop_frames", 32'(nfr), 32'd6);
        check("stop_len5", 32'(flen[5]), 32'd75);
        check("stop_sent", bus.ov_sent_cnt, 32'd6);
        check("restart_seq0", 32'(fbuf[0][25]), 32'h00);
        check("stop_seq5", 32'(fbuf[5][25]), 32'h05);

        // Stop during the gap after frame 1
        run(16'd0, 1, 2, -5, 1000);
        check("gapstop_frames", 32'(nfr), 32'd2);
        check("gapstop_gap0", 32'(gaplen[0]), 32'd12);
        check("gapstop_busy_fall", 32'(busy_fall - last_fall), 32'd12);
        check("gapstop_sent", bus.ov_sent_cnt, 32'd8);

        // Start held high with one frame per run
        run(16'd1, 200, -1, 0, 1000);
        check("held_first_en", 32'(first_en), 32'd2);
        check("held_frames", 32'(nfr), 32'd3);
        check("held_gap0", 32'(gaplen[0]), 32'd1);
        check("held_gap1", 32'(gaplen[1]), 32'd1);
        check("held_busy_falls", 32'(n_busy_fall), 32'd3);
        check("held_busy_dips", 32'(dip_total), 32'd2);
        check("held_seq_f1", 32'(fbuf[1][25]), 32'h00);
        check("held_seq_f2", 32'(fbuf[2][25]), 32'h00);
        check("held_sent", bus.ov_sent_cnt, 32'd11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
